// File: rtl/insn_loader_pkg.sv
// Shared definitions for the eBPF instruction loader: FSM encoding,
// error codes and the LDDW opcode used for pairing checks.
package insn_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TRUNC    = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_LDDW     = 2'b11;

    localparam int         WORD_BYTES = 8;
    localparam logic [7:0] BPF_LDDW   = 8'h18;

    function automatic logic is_lddw(input logic [63:0] word);
        return word[7:0] == BPF_LDDW;
    endfunction

endpackage

// File: rtl/insn_asm.sv
// Little-endian 8-byte instruction assembler: each pushed byte lands in lane
// byte_idx; full pulses for the cycle after the eighth byte is taken.
module insn_asm
    import insn_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  data,
    output logic [63:0] word,
    output logic [2:0]  byte_idx,
    output logic        full
);

    logic [2:0] idx_reg;
    logic       full_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx_reg  <= '0;
            full_reg <= 1'b0;
        end else if (push) begin
            idx_reg  <= idx_reg + 3'd1;
            full_reg <= (idx_reg == 3'(WORD_BYTES - 1));
        end
    end

    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        logic [7:0] lane_reg;

        // Lanes are cleared on reset so a discarded partial word leaves no trace.
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_reg <= '0;
            end else if (push && !clr && idx_reg == 3'(gi)) begin
                lane_reg <= data;
            end
        end

        assign word[8*gi +: 8] = lane_reg;
    end

    assign byte_idx = idx_reg;
    assign full     = full_reg;

endmodule

// File: rtl/insn_loader.sv
// Streams host bytes into 64-bit instruction slots and releases the core once
// a complete program is loaded. Optional LDDW pairing check: INSN_LOADER_LDDW_CHECK_EN.
module insn_loader
    import insn_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [63:0]       imem_wdata,
    output logic              core_hold,
    output logic              prog_done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   insn_count
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] slot_reg, slot_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              last_reg, last_next;
    logic              ready_reg, ready_next;
    logic              hold_reg, hold_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic [1:0]        code_reg, code_next;
`ifdef INSN_LOADER_LDDW_CHECK_EN
    logic              pair_reg, pair_next;
`endif

    logic        accept;
    logic        asm_clr;
    logic [2:0]  byte_idx;
    logic [63:0] word;
    logic        full;

    assign accept = s_valid && ready_reg;

    insn_asm u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (asm_clr),
        .push     (accept),
        .data     (s_data),
        .word     (word),
        .byte_idx (byte_idx),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_LOAD;
            slot_reg  <= '0;
            count_reg <= '0;
            last_reg  <= 1'b0;
            ready_reg <= 1'b1;
            hold_reg  <= 1'b1;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            code_reg  <= ERR_NONE;
`ifdef INSN_LOADER_LDDW_CHECK_EN
            pair_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
            count_reg <= count_next;
            last_reg  <= last_next;
            ready_reg <= ready_next;
            hold_reg  <= hold_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            code_reg  <= code_next;
`ifdef INSN_LOADER_LDDW_CHECK_EN
            pair_reg  <= pair_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        count_next = count_reg;
        last_next  = last_reg;
        code_next  = code_reg;
        asm_clr    = 1'b0;
`ifdef INSN_LOADER_LDDW_CHECK_EN
        pair_next  = pair_reg;
`endif

        case (state_reg)
            ST_LOAD: begin
                if (accept) begin
                    if (byte_idx == 3'(WORD_BYTES - 1)) begin
                        state_next = ST_WRITE;
                        last_next  = s_last;
                    end else if (s_last) begin
                        state_next = ST_ERR;
                        code_next  = ERR_TRUNC;
                        asm_clr    = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                asm_clr    = 1'b1;
                slot_next  = slot_reg + ADDR_W'(1);
                count_next = count_reg + (ADDR_W + 1)'(1);
                if (last_reg) begin
                    state_next = ST_DONE;
                end else if (slot_reg == '1) begin
                    state_next = ST_ERR;
                    code_next  = ERR_OVERFLOW;
                end else begin
                    state_next = ST_LOAD;
                end
`ifdef INSN_LOADER_LDDW_CHECK_EN
                // The second half of an LDDW carries immediate data, not an opcode.
                if (pair_reg) begin
                    pair_next = 1'b0;
                end else if (is_lddw(word)) begin
                    pair_next = 1'b1;
                    if (last_reg) begin
                        state_next = ST_ERR;
                        code_next  = ERR_LDDW;
                    end
                end
`endif
            end
            ST_DONE, ST_ERR: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                    slot_next  = '0;
                    count_next = '0;
                    last_next  = 1'b0;
                    code_next  = ERR_NONE;
                    asm_clr    = 1'b1;
`ifdef INSN_LOADER_LDDW_CHECK_EN
                    pair_next  = 1'b0;
`endif
                end
            end
            default: state_next = ST_LOAD;
        endcase

        ready_next = (state_next == ST_LOAD);
        hold_next  = (state_next != ST_DONE);
        done_next  = (state_next == ST_DONE);
        err_next   = (state_next == ST_ERR);
    end

    // The assembler's full flag is high exactly during the WRITE cycle.
    assign imem_we    = full;
    assign imem_addr  = slot_reg;
    assign imem_wdata = word;
    assign s_ready    = ready_reg;
    assign core_hold  = hold_reg;
    assign prog_done  = done_reg;
    assign err        = err_reg;
    assign err_code   = code_reg;
    assign insn_count = count_reg;

endmodule

// File: tb/tb_insn_loader.sv
// Self-checking bench for insn_loader: expected writes are queued as words are
// streamed and matched by a negedge monitor on imem_we.
module tb_insn_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [63:0]   imem_wdata;
    logic          core_hold;
    logic          prog_done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW:0]   insn_count;

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  wr_count = 0;

    always #5 clk = ~clk;

    insn_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .prog_done  (prog_done),
        .err        (err),
        .err_code   (err_code),
        .insn_count (insn_count)
    );

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            wr_t e;
            wr_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%016h, required no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL write_data: got addr=%0d data=%016h, required addr=%0d data=%016h",
                             imem_addr, imem_wdata, e.addr, e.data);
                end else begin
                    $display("write addr=%0d data=%016h ok", imem_addr, imem_wdata);
                end
            end
            n_checks++;
            if (s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_in_write: got s_ready=%b, required 0", s_ready);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL byte_timeout: got s_ready=0 for 50 cycles, required 1");
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_word(input logic [AW-1:0] addr, input logic [63:0] w,
                             input logic last, input int gap);
        wr_t e;
        e.addr = addr;
        e.data = w;
        exp_q.push_back(e);
        for (int k = 0; k < 8; k++) begin
            send_byte(w[8*k +: 8], last && (k == 7));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic check_status(input string name, input logic done_e, input logic hold_e,
                                input logic err_e, input logic [1:0] code_e,
                                input logic [AW:0] count_e);
        n_checks++;
        if (prog_done !== done_e || core_hold !== hold_e || err !== err_e ||
            err_code !== code_e || insn_count !== count_e) begin
            n_fail++;
            $display("FAIL %s: got done=%b hold=%b err=%b code=%b count=%0d, required done=%b hold=%b err=%b code=%b count=%0d",
                     name, prog_done, core_hold, err, err_code, insn_count,
                     done_e, hold_e, err_e, code_e, count_e);
        end else begin
            $display("%s: done=%b hold=%b err=%b code=%b count=%0d ok",
                     name, prog_done, core_hold, err, err_code, insn_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_status("reset_status", 1'b0, 1'b1, 1'b0, 2'b00, '0);
        n_checks++;
        if (s_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%0d data=%016h, required 1 0 0 0",
                     s_ready, imem_we, imem_addr, imem_wdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int w0 = wr_count;
        send_word(0, 64'h0000002A_00000107, 1'b1, 0);
        settle();
        check_status("single_done", 1'b1, 1'b0, 1'b0, 2'b00, 1);
        n_checks++;
        if (wr_count - w0 !== 1 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL single_writes: got %0d writes, required 1", wr_count - w0);
        end
    endtask

    task automatic test_restart_collision();
        @(posedge clk);
        #1;
        load_start = 1'b1;
        s_valid    = 1'b1;
        s_data     = 8'hEE;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        s_valid    = 1'b0;
        @(negedge clk);
        check_status("restart_status", 1'b0, 1'b1, 1'b0, 2'b00, 0);
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_ready: got %b, required 1", s_ready);
        end
        @(posedge clk);
        #1;
        send_word(0, 64'h11223344_55667788, 1'b1, 0);
        settle();
        check_status("restart_reload", 1'b1, 1'b0, 1'b0, 2'b00, 1);
    endtask

    task automatic test_stream();
        int w0;
        pulse_start();
        w0 = wr_count;
        send_word(0, 64'h00000000_000001B7, 1'b0, 1);
        send_word(1, 64'hFEDCBA98_76543210, 1'b0, 1);
        send_word(2, 64'h00000000_00000095, 1'b1, 1);
        settle();
        check_status("stream_done", 1'b1, 1'b0, 1'b0, 2'b00, 3);
        n_checks++;
        if (wr_count - w0 !== 3 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL stream_writes: got %0d writes, required 3", wr_count - w0);
        end
    endtask

    task automatic test_ignore_start();
        logic [63:0] w;
        wr_t e;
        w = 64'hA5A5_0F0F_C3C3_7E81;
        pulse_start();
        e.addr = 0;
        e.data = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
        pulse_start();
        for (int k = 4; k < 8; k++) send_byte(w[8*k +: 8], k == 7);
        settle();
        check_status("ignore_start", 1'b1, 1'b0, 1'b0, 2'b00, 1);
    endtask

    task automatic test_truncated();
        int w0;
        pulse_start();
        w0 = wr_count;
        send_word(0, 64'h01020304_05060708, 1'b0, 0);
        for (int k = 0; k < 5; k++) send_byte(8'h40 + 8'(k), k == 4);
        settle();
        check_status("trunc_err", 1'b0, 1'b1, 1'b1, 2'b01, 1);
        repeat (3) @(negedge clk);
        check_status("trunc_hold", 1'b0, 1'b1, 1'b1, 2'b01, 1);
        n_checks++;
        if (wr_count - w0 !== 1) begin
            n_fail++;
            $display("FAIL trunc_writes: got %0d writes, required 1", wr_count - w0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        int w0;
        pulse_start();
        w0 = wr_count;
        for (int i = 0; i < 4; i++)
            send_word(AW'(i), {32'h0BAD0000 + 32'(i), 32'h00000007}, 1'b0, 0);
        settle();
        check_status("overflow_err", 1'b0, 1'b1, 1'b1, 2'b10, 4);
        s_valid = 1'b1;
        s_data  = 8'h99;
        repeat (4) @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0 || wr_count - w0 !== 4) begin
            n_fail++;
            $display("FAIL overflow_stall: got ready=%b writes=%0d, required ready=0 writes=4",
                     s_ready, wr_count - w0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        check_status("overflow_restart", 1'b0, 1'b1, 1'b0, 2'b00, 0);
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_ready: got %b, required 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midword();
        int w0;
        w0 = wr_count;
        send_word(0, 64'h00000000_0000AAAA, 1'b0, 0);
        for (int k = 0; k < 3; k++) send_byte(8'hF0 + 8'(k), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wr_count - w0 !== 1 || insn_count !== '0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midword: got writes=%0d count=%0d ready=%b, required 1 0 1",
                     wr_count - w0, insn_count, s_ready);
        end
        @(posedge clk);
        #1;
        send_word(0, 64'h76543210_00000061, 1'b1, 0);
        settle();
        check_status("reset_reload", 1'b1, 1'b0, 1'b0, 2'b00, 1);
    endtask

    task automatic test_lddw();
        pulse_start();
        send_word(0, 64'h00000000_00000118, 1'b0, 0);
        send_word(1, 64'h00000000_00000018, 1'b1, 0);
        settle();
        check_status("lddw_pair", 1'b1, 1'b0, 1'b0, 2'b00, 2);
        pulse_start();
        send_word(0, 64'h00000000_00000095, 1'b0, 0);
        send_word(1, 64'h12345678_00000118, 1'b1, 0);
        settle();
`ifdef INSN_LOADER_LDDW_CHECK_EN
        check_status("lddw_lone", 1'b0, 1'b1, 1'b1, 2'b11, 2);
`else
        check_status("lddw_lone", 1'b1, 1'b0, 1'b0, 2'b00, 2);
`endif
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL lddw_writes: got %0d pending writes, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_restart_collision();
        test_stream();
        test_ignore_start();
        test_truncated();
        test_overflow();
        test_reset_midword();
        test_lddw();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/insn_loader.md
INSN_LOADER -- requirements
Module: insn_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, instruction-memory slot address width (2^ADDR_W 64-bit slots).
REQ-002 clk  in  1  clock; rising-edge only.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 load_start  in  1  one-cycle pulse; restarts a program load from DONE or ERR.
REQ-005 s_valid  in  1  host byte valid.
REQ-006 s_data  in  8  host byte; eBPF bytecode, little-endian.
REQ-007 s_last  in  1  qualifies the final byte of the program.
REQ-008 s_ready  out  1  loader accepts a byte this cycle.
REQ-009 imem_we  out  1  instruction-memory write strobe.
REQ-010 imem_addr  out  ADDR_W  write slot index.
REQ-011 imem_wdata  out  64  assembled instruction; byte k in bits [8k+7:8k], so the opcode is in [7:0].
REQ-012 core_hold  out  1  holds the core control FSM in reset while high.
REQ-013 prog_done  out  1  program loaded, core released.
REQ-014 err  out  1  load aborted.
REQ-015 err_code  out  2  01 truncated, 10 overflow, 11 dangling LDDW; 00 when err=0.
REQ-016 insn_count  out  ADDR_W+1  slots written in the current load.

Function
REQ-017 States: LOAD, WRITE, DONE, ERR; outputs SHALL be registered.
REQ-018 s_ready SHALL be 1 only in LOAD; a byte transfers on s_valid & s_ready at a rising edge.
REQ-019 LOAD: each accepted byte SHALL go into byte lane byte_idx (0..7), then byte_idx increments; the 8th byte SHALL move the FSM to WRITE.
REQ-020 WRITE: imem_we SHALL be 1 for exactly one cycle, with imem_addr = slot and imem_wdata = the assembled word; slot and insn_count then increment and byte_idx clears.
REQ-021 Transitions out of WRITE, in priority order:
- s_last latched with the 8th byte -> DONE.
- slot was 2^ADDR_W-1 -> ERR, code 10.
- otherwise -> LOAD.
REQ-022 s_last accepted with byte_idx != 7 -> ERR, code 01, with no memory write.
REQ-023 Throughput: 8 bytes per 9 cycles at most; the write occurs 1 cycle after the 8th byte is accepted.
REQ-024 DONE: core_hold=0 and prog_done=1; the FSM holds there until load_start or rst.
REQ-025 ERR: err=1, core_hold=1, prog_done=0; err_code holds until load_start or rst.
REQ-026 load_start in DONE or ERR SHALL:
- go to LOAD and set core_hold=1;
- clear slot, byte_idx, insn_count, err, err_code and prog_done.
REQ-027 load_start in LOAD or WRITE SHALL be ignored.
REQ-028 load_start coincident with s_valid in DONE: the restart wins and no byte is accepted that cycle.
REQ-029 Memory contents beyond insn_count are undefined; the loader never clears memory.

Reset
REQ-030 rst SHALL override every other input, including mid-word and mid-write.
REQ-031 Reset values:
- state LOAD, s_ready 1 (from the first post-reset cycle);
- imem_we 0, imem_addr 0, imem_wdata 0;
- core_hold 1, prog_done 0, err 0, err_code 00, insn_count 0.
REQ-032 A partial word SHALL be discarded on reset.

Configuration
REQ-033 Macro INSN_LOADER_LDDW_CHECK_EN, when defined:
- in WRITE, a word with opcode 0x18 marks the next slot as the LDDW second half;
- if that word is also s_last -> ERR, code 11, instead of DONE (the word is still written);
- a second-half word is never itself checked as an opcode.
REQ-034 Without INSN_LOADER_LDDW_CHECK_EN: no pairing state exists and code 11 is never produced.

Structure
REQ-035 Shared package holds the state encoding, the err_code constants and the BPF_LDDW opcode value (0x18), reused from the existing opcode definitions.
REQ-036 One sub-module, insn_asm: an 8-byte little-endian shift/lane assembler with byte_idx counter and full flag; the FSM stays in insn_loader.

Verification
REQ-037 Reset, then bytes 07 01 00 00 2A 00 00 00 with s_last on the last byte:
- one write, addr 0, data 0x0000002A_00000107;
- then prog_done=1, core_hold=0, insn_count=1.
REQ-038 Three instructions streamed with s_valid toggled 50% -> writes at addr 0, 1, 2 with exact words, and s_ready low during each WRITE cycle.
REQ-039 s_last on the 5th byte of the second instruction -> ERR code 01, exactly one write (addr 0), core_hold stays 1.
REQ-040 ADDR_W=2, 5 instructions without s_last -> 4 writes, ERR code 10 after addr 3; then load_start -> insn_count 0, s_ready 1.
REQ-041 rst asserted after 3 bytes of the second word -> no write; after reset a new word lands at addr 0.
REQ-042 With the macro defined, a program ending in a lone 0x18 word -> ERR code 11, word written at the last slot; with the macro undefined -> DONE.
